// File: rtl/text_console_writer_if.sv
// Byte-stream input plus text-RAM write port and cursor status of the console writer.
// master drives the byte stream; slave is the console writer itself.
interface text_console_writer_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic        busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data, cursor_col, cursor_row, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data, cursor_col, cursor_row, busy
    );
endinterface

// File: rtl/text_console_writer.sv
// Turns an ASCII byte stream into text-RAM cell writes; writes and cursor appear one cycle after acceptance.
// in_ready is high only in IDLE, so row and screen clears hold off the sender until the sweep finishes.
module text_console_writer #(
    parameter int         COLS  = 80,
    parameter int         ROWS  = 60,
    parameter logic [7:0] BLANK = 8'h20
) (
    input logic                  clk,
    input logic                  rst,
    text_console_writer_if.slave bus
);
    localparam int TOTAL = COLS * ROWS;

    typedef enum logic [1:0] {
        CLEAR_ALL = 2'd0,
        IDLE      = 2'd1,
        CLEAR_ROW = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [12:0] cnt_q, cnt_d;
    logic [6:0]  col_q, col_d;
    logic [5:0]  row_q, row_d;
    logic        wr_en_q, wr_en_d;
    logic [12:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;

    logic [12:0] row_base;
    logic [12:0] cell_addr;
    logic [5:0]  row_next;
    logic        accept;
    logic        printable;

    // Constant multiply; for COLS=80 this reduces to (row<<6)+(row<<4).
    assign row_base  = 13'(row_q) * 13'(COLS);
    assign cell_addr = row_base + 13'(col_q);
    assign row_next  = (row_q == 6'(ROWS - 1)) ? 6'd0 : row_q + 6'd1;
    assign accept    = bus.in_valid && (state_q == IDLE);
    assign printable = (bus.in_data >= 8'h20) && (bus.in_data <= 8'h7E);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        col_d     = col_q;
        row_d     = row_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            CLEAR_ALL: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q;
                wr_data_d = BLANK;
                if (cnt_q == 13'(TOTAL - 1)) begin
                    cnt_d   = 13'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end
            CLEAR_ROW: begin
                // Cursor already points at the freshly entered row.
                wr_en_d   = 1'b1;
                wr_addr_d = row_base + cnt_q;
                wr_data_d = BLANK;
                if (cnt_q == 13'(COLS - 1)) begin
                    cnt_d   = 13'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end
            IDLE: begin
                if (accept) begin
                    if (printable) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cell_addr;
                        wr_data_d = bus.in_data;
                        if (col_q == 7'(COLS - 1)) begin
                            col_d   = 7'd0;
                            row_d   = row_next;
                            cnt_d   = 13'd0;
                            state_d = CLEAR_ROW;
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end else begin
                        case (bus.in_data)
                            8'h0A: begin
                                col_d   = 7'd0;
                                row_d   = row_next;
                                cnt_d   = 13'd0;
                                state_d = CLEAR_ROW;
                            end
                            8'h0D: col_d = 7'd0;
                            8'h08: begin
                                if (col_q != 7'd0) begin
                                    col_d     = col_q - 7'd1;
                                    wr_en_d   = 1'b1;
                                    wr_addr_d = cell_addr - 13'd1;
                                    wr_data_d = BLANK;
                                end
                            end
                            8'h0C: begin
                                col_d   = 7'd0;
                                row_d   = 6'd0;
                                cnt_d   = 13'd0;
                                state_d = CLEAR_ALL;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: begin
                cnt_d   = 13'd0;
                state_d = CLEAR_ALL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR_ALL;
            cnt_q     <= 13'd0;
            col_q     <= 7'd0;
            row_q     <= 6'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 13'd0;
            wr_data_q <= BLANK;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            col_q     <= col_d;
            row_q     <= row_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Gated with rst so the handshake is closed during the cycle reset is first applied.
    assign bus.in_ready   = (state_q == IDLE) && !rst;
    assign bus.busy       = (state_q != IDLE) || rst;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.cursor_col = col_q;
    assign bus.cursor_row = row_q;
endmodule

// File: tb/tb_text_console_writer.sv
// Randomized and directed stimulus for text_console_writer, checked each cycle against a queue-based screen-writer model.
module tb_text_console_writer;
    localparam int         COLS  = 80;
    localparam int         ROWS  = 60;
    localparam logic [7:0] BLANK = 8'h20;
    localparam int         WAIT_LIMIT = 10000;

    logic clk;
    logic rst;
    text_console_writer_if bus_if();

    text_console_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK(BLANK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [12:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        logic [12:0] addr;
        logic [7:0]  data;
        int          cyc;
    } log_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ready_low = 0;

    wr_t  q[$];
    log_t wlog[$];
    int   m_col, m_row;
    logic exp_en, exp_ready, model_live;
    logic [12:0] exp_addr;
    logic [7:0]  exp_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    task automatic push_w(input logic en, input int addr, input int data);
        wr_t w;
        w.en   = en;
        w.addr = addr[12:0];
        w.data = data[7:0];
        q.push_back(w);
    endtask

    task automatic push_row_clear(input int row);
        for (int c = 0; c < COLS; c++) push_w(1'b1, row * COLS + c, BLANK);
    endtask

    task automatic push_screen_clear();
        for (int a = 0; a < COLS * ROWS; a++) push_w(1'b1, a, BLANK);
    endtask

    task automatic apply_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            push_w(1'b1, m_row * COLS + m_col, b);
            if (m_col == COLS - 1) begin
                m_col = 0;
                m_row = (m_row + 1) % ROWS;
                push_row_clear(m_row);
            end else begin
                m_col++;
            end
        end else if (b == 8'h0A) begin
            m_col = 0;
            m_row = (m_row + 1) % ROWS;
            push_w(1'b0, 0, 0);
            push_row_clear(m_row);
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                push_w(1'b1, m_row * COLS + m_col, BLANK);
            end
        end else if (b == 8'h0C) begin
            m_col = 0;
            m_row = 0;
            push_w(1'b0, 0, 0);
            push_screen_clear();
        end
    endtask

    task automatic model_step();
        wr_t w;
        if (rst) begin
            q.delete();
            push_screen_clear();
            m_col      = 0;
            m_row      = 0;
            exp_en     = 1'b0;
            exp_addr   = 13'd0;
            exp_data   = BLANK;
            exp_ready  = 1'b0;
            model_live = 1'b1;
        end else if (model_live) begin
            if (bus_if.in_valid && exp_ready) apply_byte(bus_if.in_data);
            if (q.size() > 0) begin
                w = q.pop_front();
                exp_en = w.en;
                if (w.en) begin
                    exp_addr = w.addr;
                    exp_data = w.data;
                end
            end else begin
                exp_en = 1'b0;
            end
            exp_ready = (q.size() == 0);
        end
    endtask

    initial begin
        model_live = 1'b0;
        exp_ready  = 1'b0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        log_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (model_live) begin
                chk("wr_en", bus_if.wr_en, exp_en);
                if (exp_en) begin
                    chk("wr_addr", bus_if.wr_addr, exp_addr);
                    chk("wr_data", bus_if.wr_data, exp_data);
                end
                chk("in_ready", bus_if.in_ready, exp_ready);
                chk("busy", bus_if.busy, !exp_ready);
                chk("cursor_col", bus_if.cursor_col, m_col);
                chk("cursor_row", bus_if.cursor_row, m_row);
                if (bus_if.in_ready !== 1'b1) ready_low++;
            end
            if (bus_if.wr_en === 1'b1) begin
                e.addr = bus_if.wr_addr;
                e.data = bus_if.wr_data;
                e.cyc  = cyc;
                wlog.push_back(e);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        int g = 0;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = b;
        while (!exp_ready && g < WAIT_LIMIT) begin
            @(negedge clk);
            g++;
        end
        if (g >= WAIT_LIMIT) chk("send_wait", bus_if.in_ready, 1);
        @(negedge clk);
    endtask

    task automatic settle();
        int g = 0;
        bus_if.in_valid = 1'b0;
        while (!exp_ready && g < WAIT_LIMIT) begin
            @(negedge clk);
            g++;
        end
        repeat (2) @(negedge clk);
        #1;
        if (g >= WAIT_LIMIT) chk("settle_ready", bus_if.in_ready, 1);
    endtask

    function automatic logic [7:0] rand_printable();
        logic [7:0] v;
        v = 8'($urandom_range(32, 126));
        return v;
    endfunction

    task automatic check_sweep(input string name, input int first, input int count);
        int bad = 0;
        chk({name, "_count"}, wlog.size(), count);
        if (wlog.size() == count) begin
            for (int i = 0; i < count; i++)
                if (wlog[i].addr !== 13'(first + i) || wlog[i].data !== BLANK) bad++;
            chk({name, "_first"}, wlog[0].addr, first);
            chk({name, "_last"}, wlog[count-1].addr, first + count - 1);
        end
        chk({name, "_bad_cells"}, bad, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] b;
        int ff_cnt = 0;
        logic found;
        rst = 1'b1;
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", bus_if.wr_en, 0);
        chk("rst_wr_addr", bus_if.wr_addr, 0);
        chk("rst_wr_data", bus_if.wr_data, 8'h20);
        chk("rst_in_ready", bus_if.in_ready, 0);
        chk("rst_busy", bus_if.busy, 1);
        chk("rst_cursor", {bus_if.cursor_row, bus_if.cursor_col}, 0);
        #1 rst = 1'b0;
        wlog.delete();
        settle();
        check_sweep("init", 0, 4800);
        chk("init_cursor", {bus_if.cursor_row, bus_if.cursor_col}, 0);

        // back-to-back "AB"
        wlog.delete();
        ready_low = 0;
        send_byte(8'h41);
        send_byte(8'h42);
        settle();
        chk("ab_count", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("ab_w0", {wlog[0].addr, wlog[0].data}, {13'd0, 8'h41});
            chk("ab_w1", {wlog[1].addr, wlog[1].data}, {13'd1, 8'h42});
            chk("ab_consecutive", wlog[1].cyc - wlog[0].cyc, 1);
        end
        chk("ab_ready_low", ready_low, 0);
        chk("ab_cursor_col", bus_if.cursor_col, 2);
        chk("ab_cursor_row", bus_if.cursor_row, 0);

        // wrap from (79,5)
        send_byte(8'h0D);
        repeat (5) send_byte(8'h0A);
        repeat (79) send_byte(rand_printable());
        settle();
        chk("prez_cursor", {bus_if.cursor_row, bus_if.cursor_col}, {6'd5, 7'd79});
        wlog.delete();
        ready_low = 0;
        send_byte(8'h5A);
        settle();
        chk("z_count", wlog.size(), 81);
        if (wlog.size() == 81) begin
            chk("z_write", {wlog[0].addr, wlog[0].data}, {13'd479, 8'h5A});
            chk("z_blank_first", wlog[1].addr, 480);
            chk("z_blank_last", wlog[80].addr, 559);
        end
        chk("z_ready_low", ready_low, 80);
        chk("z_cursor", {bus_if.cursor_row, bus_if.cursor_col}, {6'd6, 7'd0});

        // LF on the last row wraps to row 0
        repeat (53) send_byte(8'h0A);
        repeat (10) send_byte(rand_printable());
        settle();
        chk("prelf_cursor", {bus_if.cursor_row, bus_if.cursor_col}, {6'd59, 7'd10});
        wlog.delete();
        send_byte(8'h0A);
        settle();
        check_sweep("lfwrap", 0, 80);
        chk("lfwrap_cursor", {bus_if.cursor_row, bus_if.cursor_col}, 0);
        wlog.delete();
        send_byte(8'h08);
        settle();
        chk("bs_col0_count", wlog.size(), 0);
        chk("bs_col0_cursor", {bus_if.cursor_row, bus_if.cursor_col}, 0);

        // 'Q', BS, CR, BEL at column 7
        repeat (7) send_byte(rand_printable());
        wlog.delete();
        send_byte(8'h51);
        send_byte(8'h08);
        send_byte(8'h0D);
        send_byte(8'h07);
        settle();
        chk("qbs_count", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("qbs_w0", {wlog[0].addr, wlog[0].data}, {13'd7, 8'h51});
            chk("qbs_w1", {wlog[1].addr, wlog[1].data}, {13'd7, 8'h20});
        end
        chk("qbs_cursor", {bus_if.cursor_row, bus_if.cursor_col}, 0);

        // randomized mix
        for (int i = 0; i < 300; i++) begin
            int r = $urandom_range(0, 99);
            if (r < 55)      b = rand_printable();
            else if (r < 65) b = 8'h0A;
            else if (r < 72) b = 8'h0D;
            else if (r < 82) b = 8'h08;
            else if (r < 83 && ff_cnt < 2) begin b = 8'h0C; ff_cnt++; end
            else begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'h0C) b = 8'h1B;
            end
            send_byte(b);
            if ($urandom_range(0, 3) == 0) begin
                bus_if.in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        settle();

        // reset in the middle of a form-feed clear
        send_byte(8'h0C);
        bus_if.in_valid = 1'b0;
        found = 1'b0;
        for (int g = 0; g < WAIT_LIMIT && !found; g++) begin
            if (bus_if.wr_en === 1'b1 && bus_if.wr_addr == 13'd2000) found = 1'b1;
            else @(negedge clk);
        end
        chk("ff_reach_2000", found, 1);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_wr_en", bus_if.wr_en, 0);
        chk("midrst_busy", bus_if.busy, 1);
        chk("midrst_in_ready", bus_if.in_ready, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        wlog.delete();
        settle();
        check_sweep("restart", 0, 4800);
        chk("restart_cursor", {bus_if.cursor_row, bus_if.cursor_col}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: run exceeded cycle budget at cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end
endmodule
